// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM states, Ethernet framing constants and CRC helpers
package eth_pkg;

    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, DRAIN} state_t;

    localparam logic [3:0]  PRE_NIB       = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam int          HDR_BYTES_DEF = 42;

    // Mirror a 32-bit word; converts between reflected and normal CRC forms.
    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Reflected CRC-32 advanced by one nibble, least significant bit first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? bitrev32(CRC_POLY) : 32'h0);
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_nib.sv
// eth_crc32_nib: nibble-serial reflected CRC-32 register with clear and enable
module eth_crc32_nib
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [31:0] crc
);

    // Clear to the CRC seed, otherwise fold in one nibble per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) crc <= CRC_INIT;
        else if (en) crc <= crc_nib(crc, d);
    end

endmodule

// File: rtl/eth_usr_extract.sv
// eth_usr_extract: MII RX nibble stream to UDP payload bytes; FCS check under ETH_USR_FCS_CHECK_EN
module eth_usr_extract
    import eth_pkg::*;
#(
    parameter int HDR_BYTES   = HDR_BYTES_DEF,
    parameter int MAX_PAYLOAD = 1472,
    parameter int PRE_MIN     = 7
)(
    input  logic       eth_clk,
    input  logic       rst,
    input  logic [3:0] nibble,
    input  logic       nibble_valid,
    output logic [7:0] user_byte,
    output logic       user_valid,
    output logic       user_sof,
    output logic       user_eof,
    output logic       user_err
);

    localparam int NW = $clog2(2*HDR_BYTES+1);
    localparam int BW = $clog2(MAX_PAYLOAD+6);

    state_t          state;
    logic            armed;
    logic [3:0]      pre_cnt;
    logic [NW-1:0]   nib_cnt;
    logic [BW-1:0]   byte_cnt;
    logic            phase;
    logic [3:0]      low;
    logic [3:0][7:0] hold;
    logic            emitted;
    logic            fcs_bad;

`ifdef ETH_USR_FCS_CHECK_EN
    logic [31:0] crc;

    eth_crc32_nib u_crc (
        .clk (eth_clk),
        .rst (rst),
        .clr (state == PRE),
        .en  (nibble_valid && (state == HDR || state == PAY)),
        .d   (nibble),
        .crc (crc)
    );

    assign fcs_bad = bitrev32(crc) != CRC_RESIDUE;
`else
    assign fcs_bad = 1'b0;
`endif

    // Framing FSM; armed means rx_dv was low last cycle, so a frame cut by reset is drained, not parsed.
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            pre_cnt    <= '0;
            nib_cnt    <= '0;
            byte_cnt   <= '0;
            phase      <= 1'b0;
            low        <= '0;
            hold       <= '0;
            emitted    <= 1'b0;
            user_byte  <= '0;
            user_valid <= 1'b0;
            user_sof   <= 1'b0;
            user_eof   <= 1'b0;
            user_err   <= 1'b0;
        end else begin
            armed      <= !nibble_valid;
            user_valid <= 1'b0;
            user_sof   <= 1'b0;
            user_eof   <= 1'b0;
            user_err   <= 1'b0;
            case (state)
                IDLE: if (nibble_valid) begin
                    state   <= (armed && nibble == PRE_NIB) ? PRE : DRAIN;
                    pre_cnt <= 4'd1;
                end
                PRE: begin
                    if (!nibble_valid) state <= IDLE;
                    else if (nibble == PRE_NIB) pre_cnt <= pre_cnt + {3'b0, pre_cnt != 4'hF};
                    else if (nibble == SFD_NIB && pre_cnt >= 4'(PRE_MIN)) begin
                        state    <= HDR;
                        nib_cnt  <= '0;
                        byte_cnt <= '0;
                        phase    <= 1'b0;
                        emitted  <= 1'b0;
                    end else state <= DRAIN;
                end
                HDR: begin
                    if (!nibble_valid) begin
                        state    <= IDLE;
                        user_eof <= 1'b1;
                        user_err <= 1'b1;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                        if (nib_cnt == NW'(2*HDR_BYTES-1)) state <= PAY;
                    end
                end
                PAY: begin
                    if (!nibble_valid) begin
                        state    <= IDLE;
                        user_eof <= 1'b1;
                        user_err <= phase || byte_cnt < BW'(4) || fcs_bad;
                    end else begin
                        phase <= !phase;
                        if (!phase) low <= nibble;
                        else if (byte_cnt == BW'(MAX_PAYLOAD+4)) begin
                            state    <= DRAIN;
                            user_eof <= 1'b1;
                            user_err <= 1'b1;
                        end else begin
                            hold     <= {hold[2:0], nibble, low};
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt >= BW'(4)) begin
                                user_valid <= 1'b1;
                                user_byte  <= hold[3];
                                user_sof   <= !emitted;
                                emitted    <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: if (!nibble_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_usr_extract.sv
// tb_eth_usr_extract: randomized and directed frames checked cycle-by-cycle against a frame-level model
module tb_eth_usr_extract;

    localparam int HDR = 42, MAX = 1472, PMIN = 7, NC = 32768;
`ifdef ETH_USR_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    typedef logic [7:0] u8;
    typedef u8 bq_t[$];

    logic       eth_clk = 1'b0, rst = 1'b1, nibble_valid = 1'b0;
    logic [3:0] nibble = '0;
    logic [7:0] user_byte;
    logic       user_valid, user_sof, user_eof, user_err;

    int tests = 0, fails = 0, cyc = 0;
    bit ev[NC], es[NC], ee[NC], er[NC];
    u8  eb[NC];
    u8  got[$];
    int got_sof = 0, got_eof = 0, got_err = 0, sof_pos = -1;

    eth_usr_extract #(.HDR_BYTES(HDR), .MAX_PAYLOAD(MAX), .PRE_MIN(PMIN)) dut (
        .eth_clk      (eth_clk),
        .rst          (rst),
        .nibble       (nibble),
        .nibble_valid (nibble_valid),
        .user_byte    (user_byte),
        .user_valid   (user_valid),
        .user_sof     (user_sof),
        .user_eof     (user_eof),
        .user_err     (user_err)
    );

    always #5 eth_clk = ~eth_clk;

    // Edge counter: outputs seen after edge e are expected to equal the model entry e.
    always @(posedge eth_clk) cyc <= cyc + 1;

    // Byte-wise reflected CRC-32, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input u8 b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // Random header, then payload, then little-endian FCS.
    function automatic bq_t mk(input bq_t pay);
        bq_t q;
        logic [31:0] r;
        for (int i = 0; i < HDR; i++) q.push_back(u8'($urandom));
        foreach (pay[i]) q.push_back(pay[i]);
        r = '1;
        foreach (q[i]) r = crc_byte(r, q[i]);
        r = ~r;
        for (int i = 0; i < 4; i++) q.push_back(r[8*i +: 8]);
        return q;
    endfunction

    task automatic chk(input string n, input int a, input int x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, a, x);
        end
    endtask

    task automatic put(input int e, input int lim, input bit s, input bit f, input bit r, input bit v, input u8 b);
        if (e < lim && e < NC) begin
            ev[e] = v; es[e] = s; ee[e] = f; er[e] = r; eb[e] = b;
        end
    endtask

    // Drive one frame (npre x 0x5, SFD, body nibbles low-first) and record the expected output schedule.
    task automatic send(input int npre, input bq_t body, input bit odd, input int trunc, input int rst_at, input int gap);
        logic [3:0] nq[$];
        int b, s, base, p, c, lim, e;
        bit ovf, err;
        logic [31:0] r;
        got.delete(); got_sof = 0; got_eof = 0; got_err = 0; sof_pos = -1;
        for (int i = 0; i < npre; i++) nq.push_back(4'h5);
        nq.push_back(4'hD);
        foreach (body[i]) begin
            nq.push_back(body[i][3:0]);
            nq.push_back(body[i][7:4]);
        end
        if (odd) nq.push_back(4'($urandom_range(0, 15)));
        b = nq.size() - npre - 1;
        if (trunc >= 0 && trunc < b) b = trunc;
        while (nq.size() > npre + 1 + b) void'(nq.pop_back());
        s = cyc + 1;
        base = s + npre + 1;
        lim = (rst_at < 0) ? NC : s + rst_at;
        if (npre >= PMIN) begin
            p = b - 2*HDR;
            c = (p > 0) ? p / 2 : 0;
            ovf = c > MAX + 4;
            r = '1;
            for (int i = 0; i < b / 2; i++) r = crc_byte(r, body[i]);
            for (int k = 0; k + 4 < c && k < MAX; k++)
                put(base + 2*HDR + 2*(k+4) + 1, lim, k == 0, 1'b0, 1'b0, 1'b1, body[HDR+k]);
            e = ovf ? base + 2*HDR + 2*(MAX+4) + 1 : s + nq.size();
            err = ovf || p < 0 || (p % 2) != 0 || c < 4 || (FCS_EN && r != 32'hDEBB20E3);
            put(e, lim, 1'b0, 1'b1, err, 1'b0, 8'h00);
        end
        foreach (nq[i]) begin
            nibble_valid = 1'b1;
            nibble = nq[i];
            rst = (i == rst_at);
            @(posedge eth_clk); #1;
        end
        nibble_valid = 1'b0;
        rst = 1'b0;
        repeat (gap) begin @(posedge eth_clk); #1; end
    endtask

    // Per-cycle compare against the model schedule, plus a log for the directed checks.
    initial forever begin
        @(negedge eth_clk);
        if (cyc < NC) begin
            tests++;
            if (user_valid !== ev[cyc] || user_sof !== es[cyc] || user_eof !== ee[cyc] ||
                user_err !== er[cyc] || (ev[cyc] && user_byte !== eb[cyc])) begin
                fails++;
                $display("FAIL cycle %0d outputs: got v%b s%b e%b r%b b%h, expected v%b s%b e%b r%b b%h",
                         cyc, user_valid, user_sof, user_eof, user_err, user_byte,
                         ev[cyc], es[cyc], ee[cyc], er[cyc], eb[cyc]);
            end
        end
        if (user_sof) begin got_sof++; sof_pos = got.size(); end
        if (user_valid) got.push_back(user_byte);
        if (user_eof) begin got_eof++; got_err = int'(user_err); end
    end

    initial begin
        bq_t p1, f1, g, p, f;
        logic [31:0] r;
        int kind, npre;
        repeat (3) @(posedge eth_clk);
        #1;
        chk("reset_valid", int'(user_valid), 0);
        chk("reset_eof", int'(user_eof), 0);
        chk("reset_err", int'(user_err), 0);
        chk("reset_byte", int'(user_byte), 0);
        rst = 1'b0;
        repeat (3) begin @(posedge eth_clk); #1; end

        r = '1;
        for (int i = 1; i <= 9; i++) r = crc_byte(r, u8'(8'h30 + i));
        chk("crc_check_value", int'(~r), int'(32'hCBF43926));

        p1 = '{8'h11, 8'h22, 8'h33};
        f1 = mk(p1);
        send(15, f1, 1'b0, -1, -1, 4);
        chk("good_count", got.size(), 3);
        chk("good_b0", int'(got[0]), 'h11);
        chk("good_b1", int'(got[1]), 'h22);
        chk("good_b2", int'(got[2]), 'h33);
        chk("good_sof_pos", sof_pos, 0);
        chk("good_sof_n", got_sof, 1);
        chk("good_eof", got_eof, 1);
        chk("good_err", got_err, 0);

        send(5, f1, 1'b0, -1, -1, 4);
        chk("short_pre_count", got.size(), 0);
        chk("short_pre_eof", got_eof, 0);
        send(15, f1, 1'b0, -1, -1, 4);
        chk("after_short_count", got.size(), 3);
        chk("after_short_err", got_err, 0);

        send(15, f1, 1'b0, 40, -1, 4);
        chk("hdr_cut_count", got.size(), 0);
        chk("hdr_cut_eof", got_eof, 1);
        chk("hdr_cut_err", got_err, 1);

        p = {};
        for (int i = 0; i < MAX + 1; i++) p.push_back(u8'($urandom));
        f = mk(p);
        send(15, f, 1'b0, -1, -1, 4);
        chk("ovf_count", got.size(), MAX);
        chk("ovf_last", int'(got[MAX-1]), int'(p[MAX-1]));
        chk("ovf_eof", got_eof, 1);
        chk("ovf_err", got_err, 1);

        send(15, f1, 1'b1, -1, -1, 4);
        chk("odd_count", got.size(), 3);
        chk("odd_err", got_err, 1);

        g = f1;
        g[HDR+3] = g[HDR+3] ^ 8'h04;
        send(15, g, 1'b0, -1, -1, 4);
        chk("fcs_flip_count", got.size(), 3);
        chk("fcs_flip_b2", int'(got[2]), 'h33);
        chk("fcs_flip_err", got_err, int'(FCS_EN));

        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        f = mk(p);
        send(15, f, 1'b0, -1, 15 + 1 + 2*HDR + 14, 4);
        chk("rst_mid_count", got.size(), 3);
        chk("rst_mid_eof", got_eof, 0);
        send(15, f1, 1'b0, -1, -1, 2);
        chk("after_rst_count", got.size(), 3);

        repeat (40) begin
            p = {};
            for (int i = 0; i < $urandom_range(0, 40); i++) p.push_back(u8'($urandom));
            f = mk(p);
            kind = $urandom_range(0, 6);
            npre = $urandom_range(4, 15);
            if (kind == 2) f[f.size()-1] = f[f.size()-1] ^ 8'h80;
            send(npre, f, kind == 0, (kind == 1) ? $urandom_range(1, 2*f.size()) : -1,
                 (kind == 3) ? $urandom_range(0, npre + 2*f.size()) : -1, $urandom_range(1, 3));
        end

        repeat (10) begin @(posedge eth_clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
